// File: rtl/lab9_avm_cmd_initiator_if.sv
// ---------------------------------------------------------------------------
// lab9_avm_cmd_initiator_if
// Bundles the three signal groups of the command initiator:
//   - command channel  (cmd_valid/cmd_ready/cmd_write/cmd_address/cmd_writedata)
//   - response channel (rsp_valid/rsp_ready/rsp_readdata/rsp_error)
//   - Avalon-MM bus    (avm_address/avm_chipselect/avm_write_n/avm_read_n,
//                       avm_writedata/avm_readdata/avm_waitrequest)
// Modports:
//   master - the initiator's view (drives cmd_ready, rsp_*, avm_* strobes)
//   slave  - the environment's view (command source, response sink, responder)
// ---------------------------------------------------------------------------
interface lab9_avm_cmd_initiator_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_writedata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_readdata;
    logic              rsp_error;

    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic              avm_read_n;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_writedata,
        input  rsp_ready,
        input  avm_readdata, avm_waitrequest,
        output cmd_ready,
        output rsp_valid, rsp_readdata, rsp_error,
        output avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_writedata,
        output rsp_ready,
        output avm_readdata, avm_waitrequest,
        input  cmd_ready,
        input  rsp_valid, rsp_readdata, rsp_error,
        input  avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata
    );
endinterface

// File: rtl/lab9_avm_cmd_initiator.sv
// ---------------------------------------------------------------------------
// lab9_avm_cmd_initiator
// Avalon-MM initiator: accepts one command at a time, performs a single
// write or read on the bus, and returns one response per command.
//   - honours avm_waitrequest, captures read data READ_LATENCY cycles after
//     the read is accepted
//   - a saturating 16-bit watchdog aborts an access stalled for TIMEOUT
//     cycles (TIMEOUT = 0 disables it); the response then carries
//     rsp_error = 1 and rsp_readdata = 0
// Ports:
//   clk   - sole clock, rising edge
//   reset - synchronous, active-high; abandons any access, no response
//   bus   - command / response / Avalon-MM signals (master modport)
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module lab9_avm_cmd_initiator #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 0,
    parameter int TIMEOUT      = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    lab9_avm_cmd_initiator_if.master      bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RD_WAIT = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    // The latency counter is loaded with L-1 on acceptance and the capture
    // happens when it reads zero, which lands exactly L cycles after the
    // accepting ACCESS cycle.
    localparam logic [3:0]  LAT_LOAD = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    state_t            state_q,  state_d;
    logic              write_q,  write_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              error_q,  error_d;
    logic [15:0]       wd_q,     wd_d;
    logic [3:0]        lat_q,    lat_d;
    logic [15:0]       wd_inc;

    // Saturating increment: the watchdog must never wrap back to zero.
    assign wd_inc = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        wd_d    = wd_q;
        lat_d   = lat_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    write_d = bus.cmd_write;
                    addr_d  = bus.cmd_address;
                    wdata_d = bus.cmd_writedata;
                    rdata_d = '0;
                    error_d = 1'b0;
                    wd_d    = 16'd0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!bus.avm_waitrequest) begin
                    if (write_q) begin
                        state_d = S_RESP;
                    end else if (READ_LATENCY == 0) begin
                        rdata_d = bus.avm_readdata;
                        state_d = S_RESP;
                    end else begin
                        lat_d   = LAT_LOAD;
                        state_d = S_RD_WAIT;
                    end
                end else begin
                    wd_d = wd_inc;
                    if ((TIMEOUT != 0) && (wd_inc >= TO_LIMIT)) begin
                        error_d = 1'b1;
                        rdata_d = '0;
                        state_d = S_RESP;
                    end
                end
            end
            S_RD_WAIT: begin
                if (lat_q == 4'd0) begin
                    rdata_d = bus.avm_readdata;
                    state_d = S_RESP;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
            wd_q    <= 16'd0;
            lat_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            wd_q    <= wd_d;
            lat_q   <= lat_d;
        end
    end

    assign bus.cmd_ready      = (state_q == S_IDLE);
    assign bus.rsp_valid      = (state_q == S_RESP);
    assign bus.rsp_readdata   = rdata_q;
    assign bus.rsp_error      = error_q;
    assign bus.avm_address    = addr_q;
    assign bus.avm_writedata  = wdata_q;
    assign bus.avm_chipselect = (state_q == S_ACCESS);
    assign bus.avm_write_n    = !((state_q == S_ACCESS) && write_q);
    assign bus.avm_read_n     = !((state_q == S_ACCESS) && !write_q);

endmodule

// File: tb/tb_lab9_avm_cmd_initiator.sv
// ---------------------------------------------------------------------------
// tb_lab9_avm_cmd_initiator
// Two initiators share the clock: unit 0 with READ_LATENCY = 0, unit 1 with
// READ_LATENCY = 2, both with TIMEOUT = 4. The bench acts as command source,
// response sink and memory responder; expected results come from a small
// word-memory model plus the cycle arithmetic of a single access.
// ---------------------------------------------------------------------------
module tb_lab9_avm_cmd_initiator;

    localparam int TMO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst             [2];
    logic        cmd_valid       [2];
    logic        cmd_write       [2];
    logic [1:0]  cmd_address     [2];
    logic [31:0] cmd_writedata   [2];
    logic        rsp_ready       [2];
    logic [31:0] avm_readdata    [2];
    logic        avm_waitrequest [2];

    logic        o_cmd_ready [2];
    logic        o_rsp_valid [2];
    logic        o_rsp_error [2];
    logic [31:0] o_rdata     [2];
    logic [1:0]  o_addr      [2];
    logic        o_cs        [2];
    logic        o_wn        [2];
    logic        o_rn        [2];
    logic [31:0] o_wdata     [2];

    // Reference memory behind each responder.
    logic [31:0] mem [2][4];

    int n_assert = 0;
    int n_fail   = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        lab9_avm_cmd_initiator_if #(.ADDR_W(2), .DATA_W(32)) bif ();

        assign bif.cmd_valid       = cmd_valid[gi];
        assign bif.cmd_write       = cmd_write[gi];
        assign bif.cmd_address     = cmd_address[gi];
        assign bif.cmd_writedata   = cmd_writedata[gi];
        assign bif.rsp_ready       = rsp_ready[gi];
        assign bif.avm_readdata    = avm_readdata[gi];
        assign bif.avm_waitrequest = avm_waitrequest[gi];

        assign o_cmd_ready[gi] = bif.cmd_ready;
        assign o_rsp_valid[gi] = bif.rsp_valid;
        assign o_rsp_error[gi] = bif.rsp_error;
        assign o_rdata[gi]     = bif.rsp_readdata;
        assign o_addr[gi]      = bif.avm_address;
        assign o_cs[gi]        = bif.avm_chipselect;
        assign o_wn[gi]        = bif.avm_write_n;
        assign o_rn[gi]        = bif.avm_read_n;
        assign o_wdata[gi]     = bif.avm_writedata;

        lab9_avm_cmd_initiator #(
            .ADDR_W      (2),
            .DATA_W      (32),
            .READ_LATENCY((gi == 0) ? 0 : 2),
            .TIMEOUT     (TMO)
        ) dut (
            .clk  (clk),
            .reset(rst[gi]),
            .bus  (bif.master)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input int d, input string tag);
        // {cmd_ready, rsp_valid, rsp_error, chipselect, write_n, read_n}
        chk({tag, "_flags"}, 32'({o_cmd_ready[d], o_rsp_valid[d], o_rsp_error[d],
                                  o_cs[d], o_wn[d], o_rn[d]}), 32'h23);
        chk({tag, "_rdata"}, o_rdata[d], 32'd0);
        chk({tag, "_addr"},  32'(o_addr[d]), 32'd0);
        chk({tag, "_wdata"}, o_wdata[d], 32'd0);
    endtask

    // One-cycle reset pulse from wherever the unit currently is, then make
    // sure no response or bus activity leaks out afterwards.
    task automatic reset_mid(input int d, input string tag);
        bit bad;
        bad = 1'b0;
        rst[d]             = 1'b1;
        cmd_valid[d]       = 1'b0;
        rsp_ready[d]       = 1'b0;
        avm_waitrequest[d] = 1'b0;
        @(negedge clk);
        chk_reset_vals(d, {tag, "_rst"});
        rst[d] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (o_rsp_valid[d] !== 1'b0 || o_cs[d] !== 1'b0 || o_cmd_ready[d] !== 1'b1) bad = 1'b1;
        end
        chk({tag, "_quiet"}, 32'(bad), 32'd0);
        $display("txn d%0d %s: reset pulse applied", d, tag);
    endtask

    // rmode: 0 = normal, 1 = reset on second ACCESS cycle, 2 = reset in RESP
    task automatic do_txn(input int d, input bit wr, input logic [1:0] a, input logic [31:0] wd,
                          input int nwait, input int rdelay, input int rmode, input string tag);
        int lat, n, s_exp, rsp_exp, stalls, strobes, first, rsp_cyc, acc_cyc;
        bit abort, done, bus_bad, rsp_bad, rdy_bad;
        logic [31:0] exp_rd;
        lat     = (d == 0) ? 0 : 2;
        abort   = (nwait >= TMO);
        s_exp   = abort ? TMO : nwait + 1;
        rsp_exp = s_exp + 1 + ((!wr && !abort) ? lat : 0);
        exp_rd  = (wr || abort) ? 32'd0 : mem[d][a];
        n = 0; stalls = 0; strobes = 0; first = -1; rsp_cyc = -1; acc_cyc = -1;
        done = 1'b0; bus_bad = 1'b0; rsp_bad = 1'b0; rdy_bad = 1'b0;

        @(negedge clk);
        chk({tag, "_ready_idle"}, 32'(o_cmd_ready[d]), 32'd1);
        cmd_valid[d]       = 1'b1;
        cmd_write[d]       = wr;
        cmd_address[d]     = a;
        cmd_writedata[d]   = wd;
        rsp_ready[d]       = (rdelay == 0);
        avm_waitrequest[d] = 1'b0;
        avm_readdata[d]    = $urandom;

        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (o_cs[d] === 1'b1) begin
                strobes++;
                if (first < 0) first = n;
                if (o_addr[d] !== a || o_wn[d] !== !wr || o_rn[d] !== wr ||
                    (wr && o_wdata[d] !== wd)) bus_bad = 1'b1;
            end
            if (o_cmd_ready[d] !== 1'b0) rdy_bad = 1'b1;
            if (o_rsp_valid[d] === 1'b1) begin
                if (rsp_cyc < 0) rsp_cyc = n;
                if (o_cs[d] !== 1'b0 || o_rdata[d] !== exp_rd || o_rsp_error[d] !== abort)
                    rsp_bad = 1'b1;
            end
            if ((rmode == 1 && n == 2) || (rmode == 2 && o_rsp_valid[d] === 1'b1)) begin
                if (rmode == 2) chk({tag, "_pre_rst_rsp"}, 32'(rsp_bad), 32'd0);
                reset_mid(d, tag);
                return;
            end
            if (o_rsp_valid[d] === 1'b1 && (n - rsp_cyc) >= rdelay) begin
                rsp_ready[d] = 1'b1;
                cmd_valid[d] = 1'b0;
                done         = 1'b1;
            end
            // Responder: stall for nwait cycles, then accept.
            if (o_cs[d] === 1'b1) begin
                if (stalls < nwait) begin
                    avm_waitrequest[d] = 1'b1;
                    stalls++;
                end else begin
                    avm_waitrequest[d] = 1'b0;
                    acc_cyc = n;
                    if (wr) mem[d][a] = wd;
                end
            end else begin
                avm_waitrequest[d] = 1'b0;
            end
            // Valid read data only on the cycle it is due; noise otherwise.
            avm_readdata[d] = (!wr && acc_cyc >= 0 && n == acc_cyc + lat) ? mem[d][a] : $urandom;
        end

        chk({tag, "_finished"},  32'(done), 32'd1);
        chk({tag, "_strobes"},   32'(strobes), 32'(s_exp));
        chk({tag, "_first_stb"}, 32'(first), 32'd1);
        chk({tag, "_rsp_cycle"}, 32'(rsp_cyc), 32'(rsp_exp));
        chk({tag, "_bus"},       32'(bus_bad), 32'd0);
        chk({tag, "_rsp"},       32'(rsp_bad), 32'd0);
        chk({tag, "_busy"},      32'(rdy_bad), 32'd0);
        @(negedge clk);
        chk({tag, "_back_idle"}, 32'({o_rsp_valid[d], o_cmd_ready[d]}), 32'd1);
        rsp_ready[d] = 1'b0;
        $display("txn d%0d %s: wr=%0d addr=%0d wdata=%h waits=%0d hold=%0d -> strobes=%0d rsp@%0d data=%h err=%0d",
                 d, tag, wr, a, wd, nwait, rdelay, strobes, rsp_cyc, exp_rd, abort);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d]             = 1'b1;
            cmd_valid[d]       = 1'b0;
            cmd_write[d]       = 1'b0;
            cmd_address[d]     = 2'd0;
            cmd_writedata[d]   = 32'd0;
            rsp_ready[d]       = 1'b0;
            avm_readdata[d]    = 32'd0;
            avm_waitrequest[d] = 1'b0;
            for (int a = 0; a < 4; a++) mem[d][a] = $urandom;
        end
        repeat (3) @(negedge clk);
        chk_reset_vals(0, "d0_in_reset");
        chk_reset_vals(1, "d1_in_reset");
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        chk_reset_vals(0, "d0_after_reset");
        chk_reset_vals(1, "d1_after_reset");

        // Zero-wait write, then a zero-latency read of a known word.
        do_txn(0, 1'b1, 2'd0, 32'h0000_0001, 0, 0, 0, "d0_wr_a0");
        do_txn(0, 1'b1, 2'd2, 32'hDEAD_BEEF, 0, 0, 0, "d0_wr_a2");
        do_txn(0, 1'b0, 2'd2, 32'd0,         0, 0, 0, "d0_rd_a2");
        do_txn(0, 1'b0, 2'd0, 32'd0,         0, 0, 0, "d0_rd_a0");

        // Latency-2 read stretched by three waitrequest cycles.
        do_txn(1, 1'b1, 2'd1, 32'hCAFE_F00D, 0, 0, 0, "d1_wr_a1");
        do_txn(1, 1'b0, 2'd1, 32'd0,         3, 0, 0, "d1_rd_a1_w3");

        // Watchdog aborts, each followed by a normal command.
        do_txn(0, 1'b1, 2'd3, 32'h1234_5678, 9, 0, 0, "d0_wr_abort");
        do_txn(0, 1'b0, 2'd3, 32'd0,         0, 0, 0, "d0_rd_after_abort");
        do_txn(1, 1'b0, 2'd2, 32'd0,         7, 0, 0, "d1_rd_abort");
        do_txn(1, 1'b0, 2'd2, 32'd0,         2, 0, 0, "d1_rd_after_abort");

        // Response held off for 10 cycles while a new command is offered.
        do_txn(0, 1'b0, 2'd2, 32'd0, 1, 10, 0, "d0_rsp_hold");
        do_txn(1, 1'b0, 2'd1, 32'd0, 0, 10, 0, "d1_rsp_hold");

        // Reset mid-ACCESS and mid-RESP, each followed by a normal command.
        do_txn(0, 1'b1, 2'd1, 32'hAAAA_5555, 5, 0, 1, "d0_rst_access");
        do_txn(0, 1'b0, 2'd1, 32'd0,         0, 0, 0, "d0_rd_after_rst");
        do_txn(1, 1'b0, 2'd3, 32'd0,         0, 5, 2, "d1_rst_resp");
        do_txn(1, 1'b1, 2'd3, 32'h0BAD_C0DE, 1, 0, 0, "d1_wr_after_rst");
        do_txn(1, 1'b0, 2'd3, 32'd0,         0, 0, 0, "d1_rd_after_rst");

        // Random mix on both units.
        for (int i = 0; i < 24; i++) begin
            do_txn(i % 2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 0,
                   $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
